// File: rtl/id_stage_pipe.sv
// Purpose : RISC-V instruction decode with register file, WB bypass, immediate
//           generation, load-use hazard detection and an integrated ID/EX register.
// Latency : 1 cycle from an accepted i_valid/i_instr to o_valid and the decoded fields.
// Backpressure: o_ready drops on a load-use hazard or when ID/EX is full and EX stalls;
//           i_flush overrides both and kills the ID/EX contents.
//
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   i_valid / o_ready / i_instr / i_pc        IF-side handshake and instruction
//   i_wb_wr / i_wb_rd / i_wb_data             WB write port (also bypassed)
//   i_ex_is_load / i_ex_rd                    EX-stage load info for hazard detection
//   i_ex_ready / i_flush                      EX-side handshake and redirect kill
//   o_valid, o_pc, o_rs1_data, o_rs2_data, o_imm, o_opcode, o_func3,
//   o_func7b5, o_rs1, o_rs2, o_rd, o_illegal  registered ID/EX contents

module id_stage_pipe #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [31:0]     i_instr,
    input  logic [XLEN-1:0] i_pc,
    input  logic            i_wb_wr,
    input  logic [4:0]      i_wb_rd,
    input  logic [XLEN-1:0] i_wb_data,
    input  logic            i_ex_is_load,
    input  logic [4:0]      i_ex_rd,
    input  logic            i_ex_ready,
    input  logic            i_flush,
    output logic            o_valid,
    output logic [XLEN-1:0] o_pc,
    output logic [XLEN-1:0] o_rs1_data,
    output logic [XLEN-1:0] o_rs2_data,
    output logic [XLEN-1:0] o_imm,
    output logic [6:0]      o_opcode,
    output logic [2:0]      o_func3,
    output logic            o_func7b5,
    output logic [4:0]      o_rs1,
    output logic [4:0]      o_rs2,
    output logic [4:0]      o_rd,
    output logic            o_illegal
);

    localparam int AW = $clog2(NREGS);
    // One bit wider than a register index so NREGS=32 is representable.
    localparam logic [5:0] NREGS_W = 6'(NREGS);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {
        IMM_Z,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_sel_e;

    function automatic logic in_range(input logic [4:0] idx);
        return {1'b0, idx} < NREGS_W;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [XLEN-1:0] rf_q [NREGS];

    logic            valid_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] rs1_data_q, rs1_data_d;
    logic [XLEN-1:0] rs2_data_q, rs2_data_d;
    logic [XLEN-1:0] imm_q, imm_d;
    logic [6:0]      opcode_q;
    logic [2:0]      func3_q;
    logic            func7b5_q;
    logic [4:0]      rs1_q, rs2_q, rd_q;
    logic            illegal_q, illegal_d;
    // Which held operands are real sources; needed for the hold-time refresh.
    logic            rs1_use_q, rs2_use_q;

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    logic [6:0]        opcode;
    logic [4:0]        rs1_idx, rs2_idx, rd_idx;
    logic              known;
    logic              rs1_use, rs2_use, rd_use;
    imm_sel_e          imm_sel;
    logic signed [31:0] imm32;
    logic              wb_commit;
    logic [XLEN-1:0]   rs1_raw, rs2_raw;
    logic              hazard;
    logic              advance;

    assign opcode  = i_instr[6:0];
    assign rd_idx  = i_instr[11:7];
    assign rs1_idx = i_instr[19:15];
    assign rs2_idx = i_instr[24:20];

    // A WB write that really lands in the register file; only these are
    // forwarded, so an out-of-range index keeps reading zero.
    assign wb_commit = i_wb_wr && (i_wb_rd != 5'd0) && in_range(i_wb_rd);

    always_comb begin
        known   = 1'b1;
        rs1_use = 1'b1;
        rs2_use = 1'b0;
        rd_use  = 1'b0;
        imm_sel = IMM_Z;
        unique case (opcode)
            OPC_LUI:    begin rs1_use = 1'b0; rd_use = 1'b1; imm_sel = IMM_U; end
            OPC_AUIPC:  begin rs1_use = 1'b0; rd_use = 1'b1; imm_sel = IMM_U; end
            OPC_JAL:    begin rs1_use = 1'b0; rd_use = 1'b1; imm_sel = IMM_J; end
            OPC_JALR:   begin rd_use  = 1'b1; imm_sel = IMM_I; end
            OPC_BRANCH: begin rs2_use = 1'b1; imm_sel = IMM_B; end
            OPC_LOAD:   begin rd_use  = 1'b1; imm_sel = IMM_I; end
            OPC_STORE:  begin rs2_use = 1'b1; imm_sel = IMM_S; end
            OPC_OPIMM:  begin rd_use  = 1'b1; imm_sel = IMM_I; end
            OPC_OP:     begin rs2_use = 1'b1; rd_use = 1'b1; imm_sel = IMM_Z; end
            OPC_FENCE:  begin imm_sel = IMM_I; end
            OPC_SYSTEM: begin rd_use  = 1'b1; imm_sel = IMM_I; end
            default:    begin known   = 1'b0; imm_sel = IMM_Z; end
        endcase
    end

    always_comb begin
        imm32 = '0;
        unique case (imm_sel)
            IMM_I: imm32 = {{20{i_instr[31]}}, i_instr[31:20]};
            IMM_S: imm32 = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
            IMM_B: imm32 = {{19{i_instr[31]}}, i_instr[31], i_instr[7],
                            i_instr[30:25], i_instr[11:8], 1'b0};
            IMM_U: imm32 = {i_instr[31:12], 12'b0};
            IMM_J: imm32 = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12],
                            i_instr[20], i_instr[30:21], 1'b0};
            default: imm32 = '0;
        endcase
    end

    // Signed size cast sign-extends to XLEN (U-type included, as RV64 requires).
    assign imm_d = XLEN'(imm32);

    // Register read: x0 and out-of-range indices read zero; a same-cycle
    // WB write to the source wins over the stored value.
    always_comb begin
        rs1_raw = '0;
        rs2_raw = '0;
        if ((rs1_idx != 5'd0) && in_range(rs1_idx)) begin
            rs1_raw = rf_q[rs1_idx[AW-1:0]];
        end
        if ((rs2_idx != 5'd0) && in_range(rs2_idx)) begin
            rs2_raw = rf_q[rs2_idx[AW-1:0]];
        end
        if (wb_commit && (i_wb_rd == rs1_idx)) begin
            rs1_raw = i_wb_data;
        end
        if (wb_commit && (i_wb_rd == rs2_idx)) begin
            rs2_raw = i_wb_data;
        end
    end

    assign rs1_data_d = rs1_use ? rs1_raw : '0;
    assign rs2_data_d = rs2_use ? rs2_raw : '0;

    assign illegal_d = ~known
                     | (rs1_use & ~in_range(rs1_idx))
                     | (rs2_use & ~in_range(rs2_idx))
                     | (rd_use  & ~in_range(rd_idx));

    // ------------------------------------------------------------------
    // Hazard and handshake
    // ------------------------------------------------------------------
    assign hazard = i_valid & i_ex_is_load & (i_ex_rd != 5'd0)
                  & ((rs1_use & (rs1_idx == i_ex_rd)) | (rs2_use & (rs2_idx == i_ex_rd)));

    assign advance = ~valid_q | i_ex_ready;
    assign o_ready = i_flush | (~hazard & advance);

    // ------------------------------------------------------------------
    // Register file
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < NREGS; k++) begin
                rf_q[k] <= '0;
            end
        end else if (wb_commit) begin
            rf_q[i_wb_rd[AW-1:0]] <= i_wb_data;
        end
    end

    // ------------------------------------------------------------------
    // ID/EX pipeline register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q    <= 1'b0;
            pc_q       <= '0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            imm_q      <= '0;
            opcode_q   <= '0;
            func3_q    <= '0;
            func7b5_q  <= 1'b0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rd_q       <= '0;
            illegal_q  <= 1'b0;
            rs1_use_q  <= 1'b0;
            rs2_use_q  <= 1'b0;
        end else if (i_flush) begin
            valid_q <= 1'b0;
        end else if (advance) begin
            if (i_valid && !hazard) begin
                valid_q    <= 1'b1;
                pc_q       <= i_pc;
                rs1_data_q <= rs1_data_d;
                rs2_data_q <= rs2_data_d;
                imm_q      <= imm_d;
                opcode_q   <= opcode;
                func3_q    <= i_instr[14:12];
                func7b5_q  <= i_instr[30];
                rs1_q      <= rs1_idx;
                rs2_q      <= rs2_idx;
                rd_q       <= rd_idx;
                illegal_q  <= illegal_d;
                rs1_use_q  <= rs1_use;
                rs2_use_q  <= rs2_use;
            end else begin
                // Bubble: payload is don't-care and simply left as it was.
                valid_q <= 1'b0;
            end
        end else begin
            // Held by EX: keep everything, but track WB writes into the held
            // sources so EX never consumes a stale operand after the stall.
            if (wb_commit && rs1_use_q && (i_wb_rd == rs1_q)) begin
                rs1_data_q <= i_wb_data;
            end
            if (wb_commit && rs2_use_q && (i_wb_rd == rs2_q)) begin
                rs2_data_q <= i_wb_data;
            end
        end
    end

    assign o_valid    = valid_q;
    assign o_pc       = pc_q;
    assign o_rs1_data = rs1_data_q;
    assign o_rs2_data = rs2_data_q;
    assign o_imm      = imm_q;
    assign o_opcode   = opcode_q;
    assign o_func3    = func3_q;
    assign o_func7b5  = func7b5_q;
    assign o_rs1      = rs1_q;
    assign o_rs2      = rs2_q;
    assign o_rd       = rd_q;
    assign o_illegal  = illegal_q;

endmodule
